// File: rtl/fb_pkg.sv
// Shared constants and state type for the paint framebuffer port arbiter.
`timescale 1ns/1ps
package fb_pkg;

  localparam int ADDR_W  = 19;      // framebuffer address width
  localparam int DATA_W  = 8;       // colour index width
  localparam int FB_SIZE = 307200;  // 640x480 pixels

  // Source of the write side of the RAM port.
  typedef enum logic {
    IDLE  = 1'b0,  // writes come from the processor FIFO
    CLEAR = 1'b1   // writes come from the clear engine
  } fb_state_e;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bundle of the read, write, clear and RAM-side signals around the arbiter.
// slave: the arbiter's view.  master: requesters plus the RAM.
`timescale 1ns/1ps
interface fb_port_arbiter_if;
  import fb_pkg::*;

  // VGA read channel
  logic              iRD_VALID;
  logic [ADDR_W-1:0] iRD_ADDR;
  logic              oRD_READY;
  logic              oRD_DVAL;
  logic [DATA_W-1:0] oRD_DATA;

  // processor write channel
  logic              iWR_VALID;
  logic [ADDR_W-1:0] iWR_ADDR;
  logic [DATA_W-1:0] iWR_DATA;
  logic              oWR_READY;

  // clear engine control
  logic              iCLR_REQ;
  logic [DATA_W-1:0] iCLR_COLOR;
  logic              oCLR_BUSY;

  // framebuffer RAM port
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic              oMEM_WE;
  logic [DATA_W-1:0] oMEM_WDATA;
  logic [DATA_W-1:0] iMEM_RDATA;

  modport slave (
    input  iRD_VALID, iRD_ADDR, iWR_VALID, iWR_ADDR, iWR_DATA,
           iCLR_REQ, iCLR_COLOR, iMEM_RDATA,
    output oRD_READY, oRD_DVAL, oRD_DATA, oWR_READY, oCLR_BUSY,
           oMEM_ADDR, oMEM_WE, oMEM_WDATA
  );

  modport master (
    output iRD_VALID, iRD_ADDR, iWR_VALID, iWR_ADDR, iWR_DATA,
           iCLR_REQ, iCLR_COLOR, iMEM_RDATA,
    input  oRD_READY, oRD_DVAL, oRD_DATA, oWR_READY, oCLR_BUSY,
           oMEM_ADDR, oMEM_WE, oMEM_WDATA
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// First-word-fall-through FIFO buffering processor pixel writes.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
`timescale 1ns/1ps
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // An empty FIFO never pops; a full one takes a push only if it pops too.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  // Storage array: written on push only.
  // NOTE: the data array has no reset; count and pointers define validity,
  // and leaving it out keeps the array mappable to plain RAM/registers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the single framebuffer RAM port between VGA reads, buffered
// processor writes and the full-screen clear engine. Reads win unless a
// write has waited through STARVE_LIMIT consecutive read grants.
`timescale 1ns/1ps
module fb_port_arbiter #(
  parameter int FB_SIZE      = fb_pkg::FB_SIZE,
  parameter int WQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  fb_port_arbiter_if.slave  bus
);

  import fb_pkg::*;

  localparam int                CNT_W     = $clog2(WQ_DEPTH) + 1;
  localparam int                SC_W      = $clog2(STARVE_LIMIT + 1);
  localparam int                WQ_W      = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

  fb_state_e         state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_color;
  logic [SC_W-1:0]   starve_cnt;

  logic [WQ_W-1:0]   wq_head;
  logic [CNT_W-1:0]  wq_count;
  logic              wq_full;
  logic              wq_empty;
  logic              wq_push;
  logic              wq_pop;

  logic              wp;
  logic              force_w;
  logic              rd_grant;
  logic              wr_grant;
  logic [ADDR_W-1:0] wr_addr_sel;
  logic [DATA_W-1:0] wr_data_sel;

  logic              rd_s1;   // read address on the RAM port
  logic              rd_s2;   // RAM data for that read arrives
  logic              rd_dval_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;

  fb_wr_fifo #(
    .DEPTH (WQ_DEPTH),
    .WIDTH (WQ_W)
  ) u_wr_fifo (
    .clk   (iCLK),
    .rst_n (iRST_n),
    .push  (wq_push),
    .pop   (wq_pop),
    .din   ({bus.iWR_ADDR, bus.iWR_DATA}),
    .head  (wq_head),
    .count (wq_count),
    .full  (wq_full)
  );

  assign wq_empty = (wq_count == '0);
  assign wq_push  = bus.iWR_VALID && !wq_full;

  // During CLEAR the FIFO keeps accepting pushes but is never drained.
  assign wp       = ((state == IDLE) && !wq_empty) || (state == CLEAR);
  assign force_w  = wp && (starve_cnt == SC_W'(STARVE_LIMIT));
  assign rd_grant = bus.iRD_VALID && !force_w;
  assign wr_grant = wp && !rd_grant;
  assign wq_pop   = wr_grant && (state == IDLE);

  // Select the write source for the current state.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_addr_sel = wq_head[WQ_W-1:DATA_W];
    wr_data_sel = wq_head[DATA_W-1:0];
    if (state == CLEAR) begin
      wr_addr_sel = clr_addr;
      wr_data_sel = clr_color;
    end
  end

  // State machine and clear-engine address sweep.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= IDLE;
      clr_addr  <= '0;
      clr_color <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iCLR_REQ) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            clr_color <= bus.iCLR_COLOR;
          end
        end
        CLEAR: begin
          if (wr_grant) begin
            if (clr_addr == LAST_ADDR) state <= IDLE;
            else                       clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count read grants that overtake a pending write.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      starve_cnt <= '0;
    end else if (!wp || wr_grant) begin
      starve_cnt <= '0;
    end else if (rd_grant && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  // Register the winner onto the RAM port; an idle cycle holds the address.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else if (rd_grant) begin
      mem_addr_q  <= bus.iRD_ADDR;
      mem_we_q    <= 1'b0;
    end else if (wr_grant) begin
      mem_addr_q  <= wr_addr_sel;
      mem_we_q    <= 1'b1;
      mem_wdata_q <= wr_data_sel;
    end else begin
      mem_we_q    <= 1'b0;
    end
  end

  // Read-valid pipeline: address out, RAM sample, data capture.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rd_s1     <= 1'b0;
      rd_s2     <= 1'b0;
      rd_dval_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_s1     <= rd_grant;
      rd_s2     <= rd_s1;
      rd_dval_q <= rd_s2;
      if (rd_s2) rd_data_q <= bus.iMEM_RDATA;
    end
  end

  assign bus.oRD_READY  = !force_w;
  assign bus.oRD_DVAL   = rd_dval_q;
  assign bus.oRD_DATA   = rd_data_q;
  assign bus.oWR_READY  = !wq_full;
  assign bus.oCLR_BUSY  = (state == CLEAR);
  assign bus.oMEM_ADDR  = mem_addr_q;
  assign bus.oMEM_WE    = mem_we_q;
  assign bus.oMEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: a per-cycle vector table for read
// latency and the starvation guard, then hand-written sequences for FIFO
// back-pressure, the clear sweep and asynchronous reset.
`timescale 1ns/1ps
module tb_fb_port_arbiter;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fb_port_arbiter_if bus ();

  fb_port_arbiter #(
    .FB_SIZE      (16),
    .WQ_DEPTH     (4),
    .STARVE_LIMIT (8)
  ) dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Synchronous-read RAM model, preloaded with a known pattern during reset.
  logic [DATA_W-1:0] ram [256];

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
    end else if (bus.oMEM_WE) begin
      ram[bus.oMEM_ADDR[7:0]] <= bus.oMEM_WDATA;
    end
    bus.iMEM_RDATA <= ram[bus.oMEM_ADDR[7:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.iRD_VALID  = 1'b0;
    bus.iRD_ADDR   = '0;
    bus.iWR_VALID  = 1'b0;
    bus.iWR_ADDR   = '0;
    bus.iWR_DATA   = '0;
    bus.iCLR_REQ   = 1'b0;
    bus.iCLR_COLOR = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " rd_ready"},  32'(bus.oRD_READY),  32'd1);
    check({tag, " wr_ready"},  32'(bus.oWR_READY),  32'd1);
    check({tag, " rd_dval"},   32'(bus.oRD_DVAL),   32'd0);
    check({tag, " rd_data"},   32'(bus.oRD_DATA),   32'd0);
    check({tag, " clr_busy"},  32'(bus.oCLR_BUSY),  32'd0);
    check({tag, " mem_addr"},  32'(bus.oMEM_ADDR),  32'd0);
    check({tag, " mem_we"},    32'(bus.oMEM_WE),    32'd0);
    check({tag, " mem_wdata"}, 32'(bus.oMEM_WDATA), 32'd0);
  endtask

  // One table row = one clock cycle: inputs, combinational readies during the
  // cycle, and the registered RAM port / read data after the closing edge.
  typedef struct {
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              exp_rd_ready;
    logic              exp_wr_ready;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    logic              exp_dval;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rv, int ra, logic wv, int wa, int wd,
                              logic er, logic ew, logic ewe, int ea, int ewd,
                              logic edv);
    vec_t v;
    v.rd_valid     = rv;
    v.rd_addr      = ADDR_W'(ra);
    v.wr_valid     = wv;
    v.wr_addr      = ADDR_W'(wa);
    v.wr_data      = DATA_W'(wd);
    v.exp_rd_ready = er;
    v.exp_wr_ready = ew;
    v.exp_we       = ewe;
    v.exp_addr     = ADDR_W'(ea);
    v.exp_wdata    = DATA_W'(ewd);
    v.exp_dval     = edv;
    return v;
  endfunction

  // Watchdog: the whole run is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_pushed;
    int acc_cyc [5];
    int first_nready;
    int first_block;
    int first_forced;
    int we_seen;
    int dval_seen;
    int j;

    // Rows 0-5: reads to 5,6,7 back-to-back; data valid 2 clocks after accept.
    vecs[0] = mk(1, 5, 0, 0, 0,  1, 1,  0, 5, 0, 0);
    vecs[1] = mk(1, 6, 0, 0, 0,  1, 1,  0, 6, 0, 0);
    vecs[2] = mk(1, 7, 0, 0, 0,  1, 1,  0, 7, 0, 1);
    vecs[3] = mk(0, 0, 0, 0, 0,  1, 1,  0, 7, 0, 1);
    vecs[4] = mk(0, 0, 0, 0, 0,  1, 1,  0, 7, 0, 1);
    vecs[5] = mk(0, 0, 0, 0, 0,  1, 1,  0, 7, 0, 0);
    // Rows 6-18: continuous reads, one write (100, 0x3C) pushed in row 6.
    // Rows 7-14 are the 8 read grants while it waits; row 15 forces it.
    vecs[6] = mk(1, 10, 1, 100, 'h3C,  1, 1,  0, 10, 0, 0);
    for (int n = 0; n < 8; n++)
      vecs[7 + n] = mk(1, 11 + n, 0, 0, 0,  1, 1,  0, 11 + n, 0, logic'(n >= 1));
    vecs[15] = mk(1, 19, 0, 0, 0,  0, 1,  1, 100, 'h3C, 1);
    vecs[16] = mk(1, 20, 0, 0, 0,  1, 1,  0, 20,  'h3C, 1);
    vecs[17] = mk(0, 0,  0, 0, 0,  1, 1,  0, 20,  'h3C, 0);
    vecs[18] = mk(0, 0,  0, 0, 0,  1, 1,  0, 20,  'h3C, 1);

    // ---------------- reset state ----------------
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // ---------------- vector table ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.iRD_VALID = vecs[i].rd_valid;
      bus.iRD_ADDR  = vecs[i].rd_addr;
      bus.iWR_VALID = vecs[i].wr_valid;
      bus.iWR_ADDR  = vecs[i].wr_addr;
      bus.iWR_DATA  = vecs[i].wr_data;
      #1;
      check($sformatf("v%0d rd_ready", i), 32'(bus.oRD_READY), 32'(vecs[i].exp_rd_ready));
      check($sformatf("v%0d wr_ready", i), 32'(bus.oWR_READY), 32'(vecs[i].exp_wr_ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d mem_we", i),    32'(bus.oMEM_WE),    32'(vecs[i].exp_we));
      check($sformatf("v%0d mem_addr", i),  32'(bus.oMEM_ADDR),  32'(vecs[i].exp_addr));
      check($sformatf("v%0d mem_wdata", i), 32'(bus.oMEM_WDATA), 32'(vecs[i].exp_wdata));
      check($sformatf("v%0d rd_dval", i),   32'(bus.oRD_DVAL),   32'(vecs[i].exp_dval));
      if (vecs[i].exp_dval) begin
        j = (i >= 2) ? i - 2 : 0;
        check($sformatf("v%0d rd_data", i), 32'(bus.oRD_DATA),
              32'(pat(int'(vecs[j].rd_addr))));
      end
    end

    // ---------------- FIFO full under continuous reads ----------------
    n_pushed     = 0;
    first_nready = -1;
    first_block  = -1;
    first_forced = -1;
    for (int c = 0; c < 40 && n_pushed < 5; c++) begin
      @(negedge clk);
      bus.iRD_VALID = 1'b1;
      bus.iRD_ADDR  = ADDR_W'(30 + c);
      bus.iWR_VALID = 1'b1;
      bus.iWR_ADDR  = ADDR_W'(40 + n_pushed);
      bus.iWR_DATA  = DATA_W'(8'hA0 + n_pushed);
      #1;
      if (!bus.oWR_READY && first_nready < 0) first_nready = c;
      if (!bus.oRD_READY && first_block < 0)  first_block  = c;
      if (bus.oWR_READY) begin
        acc_cyc[n_pushed] = c;
        n_pushed++;
      end
      @(posedge clk);
      #1;
      if (bus.oMEM_WE && first_forced < 0) begin
        first_forced = c;
        check("fifo first write addr", 32'(bus.oMEM_ADDR),  32'd40);
        check("fifo first write data", 32'(bus.oMEM_WDATA), 32'hA0);
      end
    end
    @(negedge clk);
    drive_idle();
    check("fifo pushes accepted", 32'(n_pushed), 32'd5);
    for (int k = 0; k < 4; k++)
      check($sformatf("fifo push%0d cycle", k), 32'(acc_cyc[k]), 32'(k));
    check("fifo wr_ready drop cycle", 32'(first_nready), 32'd4);
    check("fifo rd_ready block cycle", 32'(first_block), 32'd9);
    check("fifo forced write cycle", 32'(first_forced), 32'd9);
    check("fifo push4 cycle", 32'(acc_cyc[4]), 32'd10);
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++)
      check($sformatf("fifo ram[%0d]", 40 + k), 32'(ram[40 + k]), 32'(8'hA0 + k));

    // ---------------- clear sweep, re-request and pending write ----------------
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      drive_idle();
      if (k == 0) begin
        bus.iCLR_REQ   = 1'b1;
        bus.iCLR_COLOR = 8'h07;
      end
      if (k == 5) begin
        bus.iCLR_REQ   = 1'b1;
        bus.iCLR_COLOR = 8'h55;
        bus.iWR_VALID  = 1'b1;
        bus.iWR_ADDR   = ADDR_W'(200);
        bus.iWR_DATA   = 8'h99;
      end
      @(posedge clk);
      #1;
      check($sformatf("clr c%0d busy", k), 32'(bus.oCLR_BUSY), 32'(k <= 15));
      check($sformatf("clr c%0d we", k),   32'(bus.oMEM_WE),   32'(k >= 1 && k <= 17));
      if (k >= 1 && k <= 16) begin
        check($sformatf("clr c%0d addr", k), 32'(bus.oMEM_ADDR),  32'(k - 1));
        check($sformatf("clr c%0d data", k), 32'(bus.oMEM_WDATA), 32'h07);
      end
      if (k == 17) begin
        check("clr pending addr", 32'(bus.oMEM_ADDR),  32'd200);
        check("clr pending data", 32'(bus.oMEM_WDATA), 32'h99);
      end
    end
    for (int a = 0; a < 16; a++)
      check($sformatf("clr ram[%0d]", a), 32'(ram[a]), 32'h07);
    check("clr ram[16] untouched", 32'(ram[16]), 32'(pat(16)));
    check("clr ram[200]", 32'(ram[200]), 32'h99);

    // ---------------- asynchronous reset mid-clear ----------------
    @(negedge clk);
    bus.iCLR_REQ   = 1'b1;
    bus.iCLR_COLOR = 8'h11;
    @(negedge clk);
    bus.iCLR_REQ   = 1'b0;
    bus.iWR_VALID  = 1'b1;
    bus.iWR_ADDR   = ADDR_W'(60);
    bus.iWR_DATA   = 8'h01;
    @(negedge clk);
    bus.iWR_ADDR   = ADDR_W'(61);
    bus.iWR_DATA   = 8'h02;
    @(negedge clk);
    bus.iWR_VALID  = 1'b0;
    bus.iRD_VALID  = 1'b1;
    bus.iRD_ADDR   = ADDR_W'(5);
    @(posedge clk);
    #3;
    check("async busy before reset", 32'(bus.oCLR_BUSY), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we_seen   = 0;
    dval_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.oMEM_WE)  we_seen++;
      if (bus.oRD_DVAL) dval_seen++;
    end
    check("post-reset mem_we count", 32'(we_seen),   32'd0);
    check("post-reset dval count",   32'(dval_seen), 32'd0);
    check("post-reset clr_busy",     32'(bus.oCLR_BUSY), 32'd0);
    check("post-reset wr_ready",     32'(bus.oWR_READY), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
